mem_access_ctrl: RTL
====================

Name: mem_access_ctrl

Overview:
- Sequences data-memory accesses for the execute stage (stage 2), where the result mux chooses between memory read data and the ALU result.
- Turns the stage's memread/memwrite flags into a req/ack transaction on the data-memory port.
- Stalls the pipeline until the transaction completes, then returns the read data for the result mux.
- Flags a timeout if memory never acknowledges.

Parameters:
- ADDR_W, 6, memory address width (matches the instruction memaddr field).
- DATA_W, 16, data width.
- TIMEOUT, 15, maximum REQ cycles without mem_ack before abort. Legal range 1..255.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- memread  in  1  stage-2 load request.
- memwrite  in  1  stage-2 store request.
- memaddr_in  in  ADDR_W  access address.
- wdata_in  in  DATA_W  store data (reg2 data).
- stall  out  1  pipeline hold, combinational.
- rdata_out  out  DATA_W  registered load result, for the result mux.
- rdata_valid  out  1  one-cycle pulse: rdata_out was updated.
- err  out  1  one-cycle pulse: timeout, or illegal read+write request.
- mem_req  out  1  memory request, registered.
- mem_we  out  1  1 = write, registered.
- mem_addr  out  ADDR_W  registered address.
- mem_wdata  out  DATA_W  registered write data.
- mem_rdata  in  DATA_W  memory read data, valid with mem_ack.
- mem_ack  in  1  memory completion, single-cycle.

Behaviour:
- Reset (synchronous, rst=1 at a rising edge):
  - Next state is IDLE.
  - All registered outputs (mem_req, mem_we, mem_addr, mem_wdata, rdata_out, rdata_valid, err) become 0.
  - Cycle counter cleared.
  - Applies in any state, including mid-REQ; mem_req is low from the cycle after reset is sampled.
  - A pending ack is dropped. No rdata_valid or err is produced.
- States: IDLE, REQ, DONE.
- IDLE:
  - memread XOR memwrite → latch memaddr_in, wdata_in and we=memwrite into mem_addr, mem_wdata and mem_we; set mem_req=1; clear counter; go to REQ.
  - memread AND memwrite → err pulse next cycle, no access, remain in IDLE. stall=0 (instruction discarded).
  - mem_ack is ignored.
- REQ:
  - mem_req=1; mem_addr, mem_we and mem_wdata are held stable.
  - Counter increments by 1 each cycle.
  - mem_ack=1 →
    - read: rdata_out ← mem_rdata, rdata_valid=1 next cycle.
    - write: rdata_out is unchanged.
    - mem_req ← 0; go to DONE.
  - No ack and counter == TIMEOUT-1 →
    - mem_req ← 0; err=1 next cycle.
    - For a read, rdata_out ← all ones and rdata_valid=1.
    - Go to DONE.
  - Ack on the timeout cycle: the ack wins, no err.
  - Counter width is clog2(TIMEOUT+1). The counter never wraps.
- DONE: lasts one cycle.
  - rdata_valid and err pulses are visible here.
  - memread/memwrite are ignored, because the held instruction is still present and leaves at the end of DONE.
  - Always returns to IDLE.
- stall = (IDLE and exactly one of memread/memwrite) or REQ. stall=0 in DONE.
- Latency: with mem_ack in the k-th REQ cycle, the stall lasts k+1 cycles and rdata_valid is asserted in cycle k+1 after the request. Minimum: ack in the first REQ cycle gives 2 stall cycles, and DONE is the 3rd cycle.
- Back-to-back accesses: a new request is accepted in the first IDLE cycle after DONE.
- rdata_out holds its last value between accesses.

Test Plan:
- Read, fast ack: memread=1, addr=0x05; memory acks in the 1st REQ cycle with 0xBEEF → stall high 2 cycles, mem_req/mem_addr=0x05/mem_we=0 for 1 cycle, rdata_out=0xBEEF with a rdata_valid pulse in DONE, err=0.
- Write, ack after 3 cycles: memwrite=1, addr=0x3F, wdata=0x1234 → mem_req held 3 cycles with mem_we=1 and mem_wdata=0x1234 stable, stall 4 cycles, no rdata_valid, rdata_out unchanged.
- Timeout: memread with mem_ack never asserted, TIMEOUT=15 → mem_req high exactly 15 cycles, then err and rdata_valid pulses with rdata_out=0xFFFF, then back to IDLE.
- Illegal request: memread=memwrite=1 → no mem_req, stall=0, err pulse next cycle.
- Reset mid-operation: rst=1 in the 2nd REQ cycle with ack arriving the same cycle → next cycle mem_req=0, all outputs 0, state IDLE, no rdata_valid.
- Back-to-back: read (ack in 1st REQ cycle, data 0x00AA), then a write to 0x01 presented the cycle after DONE → second mem_req starts in the cycle after acceptance; no request is generated during DONE.

Source files
------------

// File: rtl/mem_access_ctrl_if.sv
// Data-memory port bundle between the stage-2 access controller (master)
// and the data memory (slave).
interface mem_access_ctrl_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 16
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Stage-2 data-memory access sequencer: turns memread/memwrite into a req/ack
// transaction, stalls the pipeline until completion and aborts on timeout.
module mem_access_ctrl #(
  parameter int ADDR_W  = 6,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              memread,
  input  logic              memwrite,
  input  logic [ADDR_W-1:0] memaddr_in,
  input  logic [DATA_W-1:0] wdata_in,
  output logic              stall,
  output logic [DATA_W-1:0] rdata_out,
  output logic              rdata_valid,
  output logic              err,
  mem_access_ctrl_if.master mem
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rdata_valid_q, rdata_valid_d;
  logic              err_q, err_d;
  logic              one_req_s;
  logic              both_req_s;

  assign one_req_s  = memread ^ memwrite;
  assign both_req_s = memread & memwrite;

  // Pipeline hold: a legal request in IDLE, or any outstanding REQ cycle.
  assign stall = ((state_q == IDLE) && one_req_s) || (state_q == REQ);

  // Next-state and next-output computation; pulses default low every cycle.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    mem_req_d     = mem_req_q;
    mem_we_d      = mem_we_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    rdata_d       = rdata_q;
    rdata_valid_d = 1'b0;
    err_d         = 1'b0;

    case (state_q)
      IDLE: begin
        if (one_req_s) begin
          mem_addr_d  = memaddr_in;
          mem_wdata_d = wdata_in;
          mem_we_d    = memwrite;
          mem_req_d   = 1'b1;
          cnt_d       = '0;
          state_d     = REQ;
        end else if (both_req_s) begin
          err_d = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        // Ack takes priority over a timeout landing in the same cycle.
        if (mem.mem_ack) begin
          if (!mem_we_q) begin
            rdata_d       = mem.mem_rdata;
            rdata_valid_d = 1'b1;
          end else begin
            rdata_d = rdata_q;
          end
          mem_req_d = 1'b0;
          state_d   = DONE;
        end else if (cnt_q == CNT_LAST) begin
          if (!mem_we_q) begin
            rdata_d       = {DATA_W{1'b1}};
            rdata_valid_d = 1'b1;
          end else begin
            rdata_d = rdata_q;
          end
          mem_req_d = 1'b0;
          err_d     = 1'b1;
          state_d   = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  // State and registered-output flops with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      mem_req_q     <= mem_req_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      rdata_q       <= rdata_d;
      rdata_valid_q <= rdata_valid_d;
      err_q         <= err_d;
    end
  end

  assign mem.mem_req   = mem_req_q;
  assign mem.mem_we    = mem_we_q;
  assign mem.mem_addr  = mem_addr_q;
  assign mem.mem_wdata = mem_wdata_q;
  assign rdata_out     = rdata_q;
  assign rdata_valid   = rdata_valid_q;
  assign err           = err_q;

endmodule
